// File: rtl/rsa_skew_feeder.sv
// rsa_skew_feeder
//   Upstream stage of the systolic PE array. Accepts one k-slice per cycle
//   (column k of A, row k of B), applies the diagonal skew the array needs
//   and produces per-column calculation-enable / calculation-done strobes.
//   A job starts with a start pulse in IDLE and is fed slice by slice. It
//   ends on in_last or after L slices, whichever comes first. The feeder then
//   drains until the slowest lane has emitted its last strobe.
//
// Ports
//   clk, sys_rst           clock, asynchronous active-high reset
//   start                  job start pulse (only honoured in IDLE)
//   in_valid/in_ready      slice handshake; in_last marks the final slice
//   in_A  [X*RSA_DW]       A column k, lane i = [i*RSA_DW +: RSA_DW]
//   in_B  [Y*RSA_DW]       B row k,    lane j = [j*RSA_DW +: RSA_DW]
//   A_data, B_data         skewed data to the array
//   new_cal_en[Y]          per-column valid strobe
//   new_cal_done[Y]        per-column last-element strobe
//   busy                   high while feeding or draining
//   done                   one-cycle job-complete pulse
//   len_err                sticky: L slices accepted without in_last
module rsa_skew_feeder #(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [X*RSA_DW-1:0] in_A,
  input  logic [Y*RSA_DW-1:0] in_B,
  output logic [X*RSA_DW-1:0] A_data,
  output logic [Y*RSA_DW-1:0] B_data,
  output logic [Y-1:0]        new_cal_en,
  output logic [Y-1:0]        new_cal_done,
  output logic                busy,
  output logic                done,
  output logic                len_err
);

  localparam int D  = (X > Y) ? X : Y;
  localparam int KW = $clog2(L + 1);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(L - 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(D - 1);
  localparam int BW = RSA_DW + 2;   // B lane bundle: {last, valid, data}

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          len_err_reg, len_err_next;
  logic          busy_reg;
  logic          done_reg, done_next;

  logic          accept;
  logic          slot_last;

  // Slot register: the slot captured at the acceptance edge. Bubbles and
  // idle cycles load zeros so invalid slots never carry data.
  logic [X*RSA_DW-1:0] slot_a_reg;
  logic [Y*RSA_DW-1:0] slot_b_reg;
  logic                slot_valid_reg;
  logic                slot_last_reg;

  assign in_ready  = (state_reg == FEED);
  assign accept    = in_valid && in_ready;
  // The L-th slice terminates the job even without in_last.
  assign slot_last = accept && (in_last || (k_reg == K_LAST));

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    cnt_next     = cnt_reg;
    len_err_next = len_err_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = FEED;
          k_next       = '0;
          len_err_next = 1'b0;
        end
      end
      FEED: begin
        if (accept) begin
          k_next = k_reg + KW'(1);
          if ((k_reg == K_LAST) && !in_last) len_err_next = 1'b1;
          if (slot_last) begin
            state_next = DRAIN;
            cnt_next   = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        // D-1 drain cycles put done on the same edge as the slowest lane's
        // last strobe.
        if (cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      cnt_reg        <= '0;
      len_err_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      slot_a_reg     <= '0;
      slot_b_reg     <= '0;
      slot_valid_reg <= 1'b0;
      slot_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      cnt_reg        <= cnt_next;
      len_err_reg    <= len_err_next;
      busy_reg       <= (state_next != IDLE);
      done_reg       <= done_next;
      slot_a_reg     <= accept ? in_A : '0;
      slot_b_reg     <= accept ? in_B : '0;
      slot_valid_reg <= accept;
      slot_last_reg  <= slot_last;
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign len_err = len_err_reg;

  // A lane i: slot delayed by i+1 further registers.
  genvar gi;
  generate
    for (gi = 0; gi < X; gi++) begin : g_a_lane
      logic [RSA_DW-1:0] a_sr_reg [0:gi];
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          for (int s = 0; s <= gi; s++) a_sr_reg[s] <= '0;
        end else begin
          a_sr_reg[0] <= slot_a_reg[gi*RSA_DW +: RSA_DW];
          for (int s = 1; s <= gi; s++) a_sr_reg[s] <= a_sr_reg[s-1];
        end
      end
      assign A_data[gi*RSA_DW +: RSA_DW] = a_sr_reg[gi];
    end

    // B column j: data, valid and last travel together through j+1 registers.
    for (gi = 0; gi < Y; gi++) begin : g_b_lane
      logic [BW-1:0] b_sr_reg [0:gi];
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          for (int s = 0; s <= gi; s++) b_sr_reg[s] <= '0;
        end else begin
          b_sr_reg[0] <= {slot_last_reg, slot_valid_reg, slot_b_reg[gi*RSA_DW +: RSA_DW]};
          for (int s = 1; s <= gi; s++) b_sr_reg[s] <= b_sr_reg[s-1];
        end
      end
      assign B_data[gi*RSA_DW +: RSA_DW] = b_sr_reg[gi][RSA_DW-1:0];
      assign new_cal_en[gi]              = b_sr_reg[gi][RSA_DW];
      assign new_cal_done[gi]            = b_sr_reg[gi][RSA_DW+1];
    end
  endgenerate

endmodule

// File: tb/tb_rsa_skew_feeder.sv
// Testbench for rsa_skew_feeder. The reference model records the slot that
// enters the feeder at each clock edge in history arrays. It predicts every
// lane output by looking back (lane+1) edges into that history.
module tb_rsa_skew_feeder;
  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int L  = 4;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int NH = 4096;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [X*DW-1:0] in_A = '0;
  logic [Y*DW-1:0] in_B = '0;
  logic          in_ready;
  logic [X*DW-1:0] A_data;
  logic [Y*DW-1:0] B_data;
  logic [Y-1:0]  new_cal_en;
  logic [Y-1:0]  new_cal_done;
  logic          busy;
  logic          done;
  logic          len_err;

  rsa_skew_feeder #(.X(X), .Y(Y), .L(L), .RSA_DW(DW)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_A         (in_A),
    .in_B         (in_B),
    .A_data       (A_data),
    .B_data       (B_data),
    .new_cal_en   (new_cal_en),
    .new_cal_done (new_cal_done),
    .busy         (busy),
    .done         (done),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int n = 0;          // index of the last clock edge processed
  int base = 1;       // first edge whose slot is valid since reset release
  int mode = 0;       // 0 idle, 1 feeding, 2 draining
  int mk = 0;         // slices accepted in the current job
  int done_edge = -1; // edge after which done is expected
  bit merr = 1'b0;
  logic [X*DW-1:0] hist_a [NH];
  logic [Y*DW-1:0] hist_b [NH];
  bit              hist_v [NH];
  bit              hist_l [NH];

  int done_cnt = 0;
  int cd_cnt [Y];
  int en_cnt [Y];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int idx;
    chk("in_ready", in_ready, (mode == 1));
    chk("busy", busy, (mode != 0));
    chk("done", done, (n == done_edge));
    chk("len_err", len_err, merr);
    for (int i = 0; i < X; i++) begin
      idx = n - i - 1;
      chk($sformatf("A_data[%0d]@%0d", i, n), A_data[i*DW +: DW],
          (idx >= base) ? hist_a[idx][i*DW +: DW] : 16'h0);
    end
    for (int j = 0; j < Y; j++) begin
      idx = n - j - 1;
      chk($sformatf("B_data[%0d]@%0d", j, n), B_data[j*DW +: DW],
          (idx >= base) ? hist_b[idx][j*DW +: DW] : 16'h0);
      chk($sformatf("cal_en[%0d]@%0d", j, n), new_cal_en[j], (idx >= base) ? hist_v[idx] : 1'b0);
      chk($sformatf("cal_done[%0d]@%0d", j, n), new_cal_done[j], (idx >= base) ? hist_l[idx] : 1'b0);
      cd_cnt[j] += int'(new_cal_done[j]);
      en_cnt[j] += int'(new_cal_en[j]);
    end
    done_cnt += int'(done);
  endtask

  // Advance one clock edge, update the model from the inputs sampled there,
  // then compare all outputs 1 ns later.
  task automatic step();
    bit acc, lst;
    @(posedge clk);
    n++;
    acc = in_valid && (mode == 1);
    lst = acc && (in_last || (mk == L - 1));
    hist_v[n] = acc;
    hist_l[n] = lst;
    hist_a[n] = acc ? in_A : '0;
    hist_b[n] = acc ? in_B : '0;
    case (mode)
      0: if (start) begin mode = 1; mk = 0; merr = 1'b0; end
      1: if (acc) begin
           if ((mk == L - 1) && !in_last) merr = 1'b1;
           mk++;
           if (lst) begin mode = 2; done_edge = n + D; end
         end
      default: if (n == done_edge) mode = 0;
    endcase
    #1;
    check_outputs();
  endtask

  task automatic set_slice(input int k, input bit pattern);
    for (int i = 0; i < X; i++)
      in_A[i*DW +: DW] = pattern ? DW'(16*k + i) : DW'($urandom);
    for (int j = 0; j < Y; j++)
      in_B[j*DW +: DW] = pattern ? DW'(100 + 16*k + j) : DW'($urandom);
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    for (int j = 0; j < Y; j++) begin cd_cnt[j] = 0; en_cnt[j] = 0; end
  endtask

  // One job: ns slices, optional bubble after slice gap_after, optional
  // stray start pulse while slice start_at is offered.
  task automatic run_job(input int ns, input bit give_last, input int gap_after,
                         input bit pattern, input int start_at);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < ns; k++) begin
      if ((gap_after >= 0) && (k == gap_after + 1)) begin
        in_valid = 1'b0;
        set_slice(99, 1'b0);  // junk on the bus must not leak through
        step();
      end
      in_valid = 1'b1;
      in_last  = give_last && (k == ns - 1);
      set_slice(k, pattern);
      start = (k == start_at);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (D + 2) step();
  endtask

  initial begin
    clear_counts();
    // Reset state
    #1 sys_rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    sys_rst = 1'b0;

    // Idle: random in_valid is never accepted
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      set_slice(0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Back-to-back job with recognisable data
    clear_counts();
    run_job(4, 1'b1, -1, 1'b1, -1);
    chk("job1_done_pulses", done_cnt, 1);
    for (int j = 0; j < Y; j++) chk($sformatf("job1_en_cnt[%0d]", j), en_cnt[j], 4);

    // Same job with a bubble between k=1 and k=2
    run_job(4, 1'b1, 1, 1'b1, -1);

    // No in_last: L-th slice ends the job and sets len_err
    run_job(4, 1'b0, -1, 1'b0, -1);
    chk("len_err_sticky", len_err, 1'b1);

    // Random jobs (next start clears len_err), one with a stray start in FEED
    run_job(3, 1'b1, -1, 1'b0, 1);
    run_job(2, 1'b1, 0, 1'b0, -1);

    // Single-slice job
    clear_counts();
    run_job(1, 1'b1, -1, 1'b0, -1);
    chk("single_done_pulses", done_cnt, 1);
    for (int j = 0; j < Y; j++) chk($sformatf("single_cal_done[%0d]", j), cd_cnt[j], 1);

    // Asynchronous reset while draining
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; set_slice(0, 1'b0); step();
    in_last = 1'b1;  set_slice(1, 1'b0); step();
    in_valid = 1'b0; in_last = 1'b0; step();
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_A_data", A_data, 64'h0);
    chk("rst_B_data", B_data, 64'h0);
    chk("rst_cal_en", new_cal_en, 4'h0);
    chk("rst_cal_done", new_cal_done, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1 sys_rst = 1'b0;
    mode = 0; merr = 1'b0; done_edge = -1; base = n + 1;
    clear_counts();
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'($urandom);
      set_slice(0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < Y; j++) begin
      chk($sformatf("post_rst_en[%0d]", j), en_cnt[j], 0);
      chk($sformatf("post_rst_cal_done[%0d]", j), cd_cnt[j], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_skew_feeder.md
Name: rsa_skew_feeder

Overview:
- Upstream stage of the systolic PE array; drives its A_data, B_data, new_cal_en and new_cal_done inputs.
- Accepts one k-slice per cycle: column k of A (X elements) plus row k of B (Y elements).
- Applies the diagonal skew the array needs: A row i is delayed i cycles, B column j is delayed j cycles.
- Generates per-column calculation-enable and calculation-done strobes, and controls stream start, length and drain.

Parameters:
- X, 4, PE rows (A lanes).
- Y, 4, PE columns (B lanes).
- L, 4, maximum stream length (k-slices per job).
- RSA_DW, 16, signed element width.

Ports:
- clk  in  1  clock.
- sys_rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- in_valid  in  1  in_A/in_B/in_last valid.
- in_ready  out  1  slice accepted when in_valid && in_ready.
- in_last  in  1  marks the final slice of the job.
- in_A  in  X*RSA_DW  A column k; lane i = [i*RSA_DW +: RSA_DW].
- in_B  in  Y*RSA_DW  B row k; lane j = [j*RSA_DW +: RSA_DW].
- A_data  out  X*RSA_DW  skewed A to the array.
- B_data  out  Y*RSA_DW  skewed B to the array.
- new_cal_en  out  Y  per-column valid strobe.
- new_cal_done  out  Y  per-column last-element strobe.
- busy  out  1  high in FEED or DRAIN.
- done  out  1  one-cycle job-complete pulse.
- len_err  out  1  sticky; L slices accepted without in_last.

Behaviour:
- Reset (async, sys_rst=1): state=IDLE; all skew registers, A_data, B_data, new_cal_en, new_cal_done, busy, done and len_err = 0; k-counter = 0.
- States: IDLE, FEED, DRAIN. D = max(X,Y).
- IDLE:
  - in_ready=0.
  - On start: go to FEED, k=0, clear len_err.
- FEED:
  - in_ready=1.
  - Each cycle, one "slot" enters every lane's delay line.
  - Accepted cycle: slot = (in_A, in_B, valid=1, last=in_last || k==L-1); k increments.
  - Cycle without acceptance (bubble): slot = zeros, valid=0, last=0.
  - On accepting a slot with last=1: go to DRAIN, drain counter = D-1.
  - If that slot had k==L-1 and in_last=0, set len_err.
- DRAIN:
  - in_ready=0; zero/invalid slots are injected.
  - Counter decrements each cycle. At 0: go to IDLE and pulse done for one cycle. done falls at or after the cycle in which the slowest lane's last strobe appears.
- Skew:
  - A lane i output = slot A lane i registered i+1 times.
  - B lane j output = slot B lane j registered j+1 times.
  - new_cal_en[j] = slot valid delayed j+1.
  - new_cal_done[j] = slot last delayed j+1.
  - The acceptance edge is edge 0, so lane 0 shows the slot after edge 1.
- Invalid slots always drive data 0 so the MACs accumulate nothing.
- busy = (state != IDLE), registered together with the state.
- start in FEED or DRAIN: ignored.
- in_valid while in IDLE or DRAIN: not accepted; the source must hold the slice.
- Single-slice job (in_last on the first accept): FEED lasts one accept, then DRAIN.
- Reset mid-job: everything clears immediately. No partial strobes appear after reset is released.
- No arithmetic: data passes bit-exact, sign untouched.

Test Plan:
- Reset release, no stimulus:
  - All outputs 0.
  - in_ready=0.
  - Random in_valid is never accepted.
- X=Y=L=4, start, then 4 back-to-back slices A_k lane i = 16*k+i and B_k lane j = 100+16*k+j, in_last on k=3:
  - A_data lane i shows 16*k+i at edge k+i+1.
  - new_cal_en[j] is high for edges j+1..j+4.
  - new_cal_done[j] is high only at edge j+4.
  - done pulses once; len_err=0.
- Same job with in_valid low for one cycle between k=1 and k=2:
  - A_data/B_data show zeros in that skewed slot.
  - new_cal_en[j] has a one-cycle hole shifted by j.
  - The data sequence is otherwise intact.
- 4 slices with in_last never asserted:
  - The 4th accept is treated as last.
  - FEED goes to DRAIN, len_err=1 and stays set.
  - The next start clears len_err.
- start pulsed during FEED, and start pulsed with in_last on the first slice:
  - The first start has no effect.
  - A single-slice job gives exactly one new_cal_done pulse per column, followed by done.
- sys_rst asserted asynchronously while in DRAIN:
  - Outputs clear immediately without waiting for a clock.
  - busy=0.
  - After release, no new_cal_en or new_cal_done pulses appear.
